uart_rx_fifo: RTL

Parametrised UART receiver with mid-bit sampling, configurable frame format (data bits, parity, stop bits) and per-frame error flags. Received frames are buffered in an on-chip FIFO drained through a valid/ready handshake. It replaces the fixed 8N1 receiver on the host serial link: it absorbs bursts from the laptop while downstream logic is busy, and reports corrupted frames instead of silently passing them on.

---
 rtl/uart_rx_fifo.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with mid-bit sampling and a configurable frame format
//   (DATA_BITS data bits, optional even/odd parity, 1 or 2 stop bits).
//   Every completed frame is written, with its parity and framing error
//   flags, into a first-word-fall-through FIFO that the consumer drains.
//
// Ports
//   clk_in          sole clock, rising edge
//   rst_in          asynchronous active-high reset
//   uart_rxd_in     serial line, idle high, asynchronous to clk_in
//   data_out        head-of-FIFO data, LSB = first bit received (0 when empty)
//   parity_err_out  head entry had a parity mismatch (0 when empty)
//   frame_err_out   head entry had a low stop bit (0 when empty)
//   valid_out       FIFO non-empty, head fields valid
//   ready_in        consumer accepts the head entry
//   count_out       FIFO occupancy
//   overflow_out    sticky: a frame was dropped because the FIFO was full
//   clr_overflow_in one-cycle pulse clearing overflow_out (a same-cycle
//                   overflow wins)
//
// Handshake: the head entry is transferred on every rising edge where
// valid_out && ready_in are both high. valid_out does not depend on ready_in,
// and a frame pushed into an empty FIFO becomes visible one cycle later.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 3_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            uart_rxd_in,
  output logic [DATA_BITS-1:0]            data_out,
  output logic                            parity_err_out,
  output logic                            frame_err_out,
  output logic                            valid_out,
  input  logic                            ready_in,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_out,
  output logic                            overflow_out,
  input  logic                            clr_overflow_in
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = $clog2(FIFO_DEPTH + 1);
  localparam int EW   = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_RECOVER
  } state_t;

  // Receiver state; state_q is the observable FSM state.
  state_t                 state_q, state_d;
  logic                   sync1_q, rxd_s_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ferr_now;
  logic                   par_x;
  logic                   push;
  logic [EW-1:0]          push_word;

  // FIFO state
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]          fcnt_q, fcnt_d;
  logic                   ovf_q, ovf_d;
  logic                   full, pop, push_ok;
  logic [EW-1:0]          head;

  // Two-flop synchronizer, idle-high reset so reset does not look like a start.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      sync1_q <= uart_rxd_in;
      rxd_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Framing error of the frame so far, including the stop bit being sampled now.
  assign ferr_now  = ferr_q | ~rxd_s_q;
  assign par_x     = ^{shift_q, rxd_s_q};
  assign push_word = {ferr_now, perr_q, shift_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxd_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            state_d = S_IDLE;       // line went back high: glitch
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d   = '0;
          perr_d  = (PARITY == 2) ? ~par_x : par_x;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d  = '0;
          ferr_d = ferr_now;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            push    = 1'b1;
            // A low stop bit may be a break; wait for idle before re-arming.
            state_d = ferr_now ? S_RECOVER : S_IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RECOVER: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: separate occupancy counter; a full FIFO still accepts a push when
  // the same edge pops.
  assign full      = (fcnt_q == NW'(FIFO_DEPTH));
  assign valid_out = (fcnt_q != '0);
  assign pop       = valid_out & ready_in;
  assign push_ok   = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop)      fcnt_d = fcnt_q + NW'(1);
    else if (!push_ok && pop) fcnt_d = fcnt_q - NW'(1);
    if (clr_overflow_in)      ovf_d = 1'b0;
    if (push && !push_ok)     ovf_d = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr_q] <= push_word;
  end

  assign head           = valid_out ? mem[rd_ptr_q] : '0;
  assign data_out       = head[DATA_BITS-1:0];
  assign parity_err_out = head[DATA_BITS];
  assign frame_err_out  = head[DATA_BITS+1];
  assign count_out      = fcnt_q;
  assign overflow_out   = ovf_q;

endmodule
